// File: rtl/capture_pkg.sv
// Shared types and defaults for the capture sequencer.
package capture_pkg;

  localparam int unsigned SAMPLE_WIDTH_DEF = 8;
  localparam int unsigned ADDR_WIDTH_DEF   = 10;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARM       = 3'd1,
    ST_PRE_FILL  = 3'd2,
    ST_WAIT_TRIG = 3'd3,
    ST_POST      = 3'd4,
    ST_DONE      = 3'd5
  } cap_state_e;

  // States in which one sample is written to the buffer each cycle.
  function automatic logic is_write_state(input cap_state_e s);
    return (s == ST_PRE_FILL) || (s == ST_WAIT_TRIG) || (s == ST_POST);
  endfunction

  // States that count as "capture in progress".
  function automatic logic is_busy_state(input cap_state_e s);
    return (s == ST_ARM) || is_write_state(s);
  endfunction

  // States during which the trigger block is held armed (cleared).
  function automatic logic is_arm_state(input cap_state_e s);
    return (s == ST_ARM) || (s == ST_PRE_FILL);
  endfunction

endpackage

// File: rtl/capture_addr_gen.sv
// Circular write-pointer generator: clear to zero, step by one when enabled,
// wrapping naturally at 2^ADDR_WIDTH.
module capture_addr_gen
  import capture_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  clear_i,
  input  logic                  enable_i,
  output logic [ADDR_WIDTH-1:0] addr_o
);

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] addr_d;

  // Next pointer value: clear wins over increment.
  always_comb begin
    addr_d = addr_q;
    if (clear_i) begin
      addr_d = '0;
    end else if (enable_i) begin
      addr_d = addr_q + ADDR_WIDTH'(1);
    end else begin
      addr_d = addr_q;
    end
  end

  // Pointer register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/capture_sequencer.sv
// Logic-analyser style capture sequencer: arms the trigger block, fills a
// pre-trigger window, writes circularly until the trigger, then writes a
// post-trigger window and reports completion.
module capture_sequencer
  import capture_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH   = ADDR_WIDTH_DEF
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [SAMPLE_WIDTH-1:0] cfg_rise,
  input  logic [SAMPLE_WIDTH-1:0] cfg_fall,
  input  logic [ADDR_WIDTH-1:0]   cfg_pre,
  input  logic [ADDR_WIDTH-1:0]   cfg_post,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
  input  logic                    trig_run,
  output logic                    trig_arm,
  output logic [SAMPLE_WIDTH-1:0] trig_rise,
  output logic [SAMPLE_WIDTH-1:0] trig_fall,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [SAMPLE_WIDTH-1:0] mem_data,
  output logic [ADDR_WIDTH-1:0]   trig_addr,
  output logic                    busy,
  output logic                    done
);

  cap_state_e state_q;
  cap_state_e state_d;

  logic [SAMPLE_WIDTH-1:0] rise_q;
  logic [SAMPLE_WIDTH-1:0] fall_q;
  logic [ADDR_WIDTH-1:0]   pre_q;
  logic [ADDR_WIDTH-1:0]   post_q;
  logic [ADDR_WIDTH-1:0]   cnt_q;
  logic [ADDR_WIDTH-1:0]   trig_addr_q;
  logic                    mem_we_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic [SAMPLE_WIDTH-1:0] mem_data_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    trig_arm_q;

  logic [ADDR_WIDTH-1:0]   ptr_s;
  logic [ADDR_WIDTH:0]     room_s;
  logic [ADDR_WIDTH:0]     pre_ext_s;
  logic [ADDR_WIDTH-1:0]   eff_pre_s;
  logic [ADDR_WIDTH:0]     cnt_inc_s;
  logic                    start_ok_s;
  logic                    write_s;
  logic                    trig_hit_s;
  logic                    pre_last_s;
  logic                    post_last_s;

  // Clamp the pre-trigger window so pre + trigger + post fits the buffer.
  // Done one bit wider so the subtraction can never wrap.
  always_comb begin
    room_s    = {1'b0, {ADDR_WIDTH{1'b1}}} - {1'b0, cfg_post};
    pre_ext_s = {1'b0, cfg_pre};
    if (pre_ext_s < room_s) begin
      eff_pre_s = cfg_pre;
    end else begin
      eff_pre_s = room_s[ADDR_WIDTH-1:0];
    end
  end

  // Qualified control strobes; abort suppresses everything else.
  always_comb begin
    start_ok_s  = start && !abort && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    write_s     = !abort && is_write_state(state_q);
    trig_hit_s  = !abort && (state_q == ST_WAIT_TRIG) && trig_run;
    cnt_inc_s   = {1'b0, cnt_q} + {{ADDR_WIDTH{1'b0}}, 1'b1};
    pre_last_s  = (cnt_inc_s == {1'b0, pre_q});
    post_last_s = (cnt_inc_s == {1'b0, post_q});
  end

  // Next-state selection for the capture sequence.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:      state_d = start ? ST_ARM : ST_IDLE;
        ST_ARM:       state_d = (pre_q == '0) ? ST_WAIT_TRIG : ST_PRE_FILL;
        ST_PRE_FILL:  state_d = pre_last_s ? ST_WAIT_TRIG : ST_PRE_FILL;
        ST_WAIT_TRIG: begin
          if (trig_run) begin
            state_d = (post_q == '0) ? ST_DONE : ST_POST;
          end else begin
            state_d = ST_WAIT_TRIG;
          end
        end
        ST_POST:      state_d = post_last_s ? ST_DONE : ST_POST;
        ST_DONE:      state_d = start ? ST_ARM : ST_DONE;
        default:      state_d = ST_IDLE;
      endcase
    end
  end

  // State register plus status outputs registered from the next state so
  // they line up with the state they describe.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      trig_arm_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= is_busy_state(state_d);
      done_q     <= (state_d == ST_DONE);
      trig_arm_q <= is_arm_state(state_d);
    end
  end

  // Configuration latch, phase counter, buffer write port and trigger address.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rise_q      <= '0;
      fall_q      <= '0;
      pre_q       <= '0;
      post_q      <= '0;
      cnt_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      trig_addr_q <= '0;
    end else begin
      if (start_ok_s) begin
        rise_q <= cfg_rise;
        fall_q <= cfg_fall;
        pre_q  <= eff_pre_s;
        post_q <= cfg_post;
      end
      // The counter restarts on every state change, so each window counts from 0.
      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if ((state_q == ST_PRE_FILL) || (state_q == ST_POST)) begin
        cnt_q <= cnt_inc_s[ADDR_WIDTH-1:0];
      end
      mem_we_q <= write_s;
      if (write_s) begin
        mem_addr_q <= ptr_s;
        mem_data_q <= sample_in;
      end
      if (trig_hit_s) begin
        trig_addr_q <= ptr_s;
      end
    end
  end

  capture_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_gen (
    .clk_i    (clock),
    .rst_n_i  (reset_n),
    .clear_i  (start_ok_s),
    .enable_i (write_s),
    .addr_o   (ptr_s)
  );

  assign trig_arm  = trig_arm_q;
  assign trig_rise = rise_q;
  assign trig_fall = fall_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_data  = mem_data_q;
  assign trig_addr = trig_addr_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer with a write-count based reference model.
module tb_capture_sequencer;

  localparam int SW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [SW-1:0] cfg_rise = '0;
  logic [SW-1:0] cfg_fall = '0;
  logic [AW-1:0] cfg_pre = '0;
  logic [AW-1:0] cfg_post = '0;
  logic [SW-1:0] sample_in = '0;
  logic          trig_run = 1'b0;
  logic          trig_arm;
  logic [SW-1:0] trig_rise;
  logic [SW-1:0] trig_fall;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [SW-1:0] mem_data;
  logic [AW-1:0] trig_addr;
  logic          busy;
  logic          done;

  capture_sequencer #(.SAMPLE_WIDTH(SW), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
    .cfg_rise(cfg_rise), .cfg_fall(cfg_fall), .cfg_pre(cfg_pre), .cfg_post(cfg_post),
    .sample_in(sample_in), .trig_run(trig_run), .trig_arm(trig_arm),
    .trig_rise(trig_rise), .trig_fall(trig_fall), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_data(mem_data), .trig_addr(trig_addr), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Writes observed on the DUT port (address and cycle), cleared per scenario.
  logic [AW-1:0] wr_addrs[$];
  int            wr_cyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a capture is described by how many samples it has written
  // (m_nw), the clamped pre window, the post length and the write index of
  // the trigger sample.
  bit            m_valid = 0;
  bit            m_cap = 0;
  bit            m_arm = 0;
  bit            m_done = 0;
  bit            m_we = 0;
  bit            m_mdz = 0;
  int            m_nw = 0;
  int            m_tw = -1;
  int            m_pre = 0;
  int            m_post = 0;
  logic [AW-1:0] m_addr = '0;
  logic [SW-1:0] m_data = '0;
  logic [AW-1:0] m_taddr = '0;
  logic [SW-1:0] m_rise = '0;
  logic [SW-1:0] m_fall = '0;

  initial begin
    forever begin
      @(negedge clock);
      cyc++;
      if (m_valid) begin
        chk("busy", busy, m_cap);
        chk("done", done, m_done);
        chk("trig_arm", trig_arm, m_cap && (m_arm || (m_nw < m_pre)));
        chk("mem_we", mem_we, m_we);
        chk("trig_rise", trig_rise, m_rise);
        chk("trig_fall", trig_fall, m_fall);
        chk("trig_addr", trig_addr, m_taddr);
        if (m_we || m_mdz) begin
          chk("mem_addr", mem_addr, m_addr);
          chk("mem_data", mem_data, m_data);
        end
      end
      if (mem_we === 1'b1) begin
        wr_addrs.push_back(mem_addr);
        wr_cyc.push_back(cyc);
      end
      // Advance the model with the inputs the next edge will sample.
      if (!reset_n) begin
        m_valid = 1; m_cap = 0; m_arm = 0; m_done = 0; m_we = 0; m_mdz = 1;
        m_addr = '0; m_data = '0; m_taddr = '0; m_rise = '0; m_fall = '0;
        m_pre = 0; m_post = 0; m_nw = 0; m_tw = -1;
      end else if (abort) begin
        m_cap = 0; m_arm = 0; m_done = 0; m_we = 0;
      end else if (start && !m_cap) begin
        m_rise = cfg_rise; m_fall = cfg_fall;
        m_post = int'(cfg_post);
        m_pre = (int'(cfg_pre) < (DEPTH - 1 - m_post)) ? int'(cfg_pre) : (DEPTH - 1 - m_post);
        m_cap = 1; m_arm = 1; m_done = 0; m_we = 0; m_nw = 0; m_tw = -1;
      end else if (m_cap && m_arm) begin
        m_arm = 0; m_we = 0;
      end else if (m_cap) begin
        m_we = 1; m_mdz = 0;
        m_addr = AW'(m_nw % DEPTH);
        m_data = sample_in;
        if ((m_tw < 0) && (m_nw >= m_pre) && trig_run) begin
          m_tw = m_nw;
          m_taddr = m_addr;
        end
        m_nw++;
        if ((m_tw >= 0) && (m_nw == m_tw + 1 + m_post)) begin
          m_cap = 0; m_done = 1;
        end
      end else begin
        m_we = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    sample_in = SW'($urandom);
  endtask

  task automatic wait_done(input int max_cycles, input string name);
    int n = 0;
    while ((done !== 1'b1) && (n < max_cycles)) begin
      tick();
      n++;
    end
    chk(name, done, 1);
  endtask

  task automatic kick(input int pre, input int post, input logic [SW-1:0] r, input logic [SW-1:0] f);
    wr_addrs.delete();
    wr_cyc.delete();
    cfg_pre = AW'(pre); cfg_post = AW'(post); cfg_rise = r; cfg_fall = f;
    start = 1'b1;
    tick();
    start = 1'b0;
    cfg_rise = ~r; cfg_fall = ~f;
  endtask

  initial begin
    bit found;
    // Reset state
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_outs", {trig_arm, trig_rise, trig_fall, mem_addr, mem_data, trig_addr}, 0);
    reset_n = 1'b1;
    tick();

    // S1: pre=3 post=2, trigger 5 cycles into WAIT_TRIG
    kick(3, 2, 8'h81, 8'h42);
    repeat (1 + 3 + 5) tick();
    trig_run = 1'b1; tick(); trig_run = 1'b0;
    repeat (4) tick();
    chk("s1_trig_addr", trig_addr, 8);
    chk("s1_done", done, 1);
    chk("s1_rise_latched", trig_rise, 8'h81);
    chk("s1_writes", wr_addrs.size(), 11);
    if (wr_addrs.size() == 11) begin
      chk("s1_post_addr0", wr_addrs[9], 9);
      chk("s1_post_addr1", wr_addrs[10], 10);
    end

    // S2: pre=0 post=0, restart from DONE, trigger on first WAIT_TRIG cycle
    kick(0, 0, 8'h00, 8'h00);
    tick();
    trig_run = 1'b1; tick(); trig_run = 1'b0;
    chk("s2_done_next", done, 1);
    chk("s2_we", mem_we, 1);
    chk("s2_addr", mem_addr, 0);
    chk("s2_trig_addr", trig_addr, 0);
    tick();
    chk("s2_we_off", mem_we, 0);
    tick();
    chk("s2_writes", wr_addrs.size(), 1);

    // S3: pre=15 post=4 -> clamped pre of 11, trig_run held through PRE_FILL
    kick(15, 4, 8'h0F, 8'hF0);
    trig_run = 1'b1;
    wait_done(40, "s3_timeout");
    trig_run = 1'b0;
    repeat (2) tick();
    chk("s3_trig_addr", trig_addr, 11);
    chk("s3_writes", wr_addrs.size(), 16);

    // S4: WAIT_TRIG held 20 cycles, pointer wraps 15 -> 0
    kick(2, 1, 8'h11, 8'h22);
    repeat (1 + 2 + 20) tick();
    trig_run = 1'b1; tick(); trig_run = 1'b0;
    repeat (3) tick();
    found = 0;
    for (int i = 0; i + 1 < wr_addrs.size(); i++) begin
      if ((wr_addrs[i] == 4'd15) && (wr_addrs[i+1] == 4'd0) && (wr_cyc[i+1] == wr_cyc[i] + 1)) found = 1;
    end
    chk("s4_wrap", found, 1);
    chk("s4_trig_addr", trig_addr, 6);
    chk("s4_writes", wr_addrs.size(), 24);

    // S5: abort and trig_run in the same POST cycle
    kick(2, 5, 8'hA5, 8'h5A);
    repeat (1 + 2) tick();
    trig_run = 1'b1; tick(); trig_run = 1'b0;
    tick();
    abort = 1'b1; trig_run = 1'b1;
    tick();
    abort = 1'b0; trig_run = 1'b0;
    chk("s5_we", mem_we, 0);
    chk("s5_busy", busy, 0);
    chk("s5_done", done, 0);
    chk("s5_arm", trig_arm, 0);
    repeat (3) tick();
    chk("s5_done_stays", done, 0);
    chk("s5_writes", wr_addrs.size(), 4);

    // S6: reset mid-POST, then a full capture
    kick(1, 6, 8'h3C, 8'hC3);
    repeat (1 + 1) tick();
    trig_run = 1'b1; tick(); trig_run = 1'b0;
    repeat (2) tick();
    chk("s6_in_post", busy, 1);
    reset_n = 1'b0;
    tick();
    chk("s6_rst_flags", {busy, done, trig_arm, mem_we}, 0);
    chk("s6_rst_data", {trig_rise, trig_fall, mem_addr, mem_data, trig_addr}, 0);
    reset_n = 1'b1;
    tick();
    kick(3, 3, 8'h5A, 8'h96);
    trig_run = 1'b1;
    wait_done(40, "s6_timeout");
    trig_run = 1'b0;
    repeat (2) tick();
    chk("s6_trig_addr", trig_addr, 3);
    chk("s6_writes", wr_addrs.size(), 7);
    chk("s6_rise", trig_rise, 8'h5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/capture_sequencer.md
CAPTURE_SEQUENCER -- requirements
Module: capture_sequencer

Interface
REQ-001 The module SHALL use one clock and a synchronous, active-low reset, named clock and reset_n.
REQ-002 Parameters SHALL be:
- SAMPLE_WIDTH, default 8, number of sampled channels.
- ADDR_WIDTH, default 10, capture buffer address width (depth 2^ADDR_WIDTH).
REQ-003 Ports SHALL be:
- clock  in  1  system clock, rising edge
- reset_n  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse, begin capture
- abort  in  1  one-cycle pulse, cancel capture
- cfg_rise  in  SAMPLE_WIDTH  per-channel rising-edge trigger select
- cfg_fall  in  SAMPLE_WIDTH  per-channel falling-edge trigger select
- cfg_pre  in  ADDR_WIDTH  pre-trigger sample count
- cfg_post  in  ADDR_WIDTH  post-trigger sample count
- sample_in  in  SAMPLE_WIDTH  live channel samples
- trig_run  in  1  trigger-hit indication from trigger block
- trig_arm  out  1  arm (clear) to trigger block
- trig_rise  out  SAMPLE_WIDTH  latched rise select to trigger block
- trig_fall  out  SAMPLE_WIDTH  latched fall select to trigger block
- mem_we  out  1  buffer write enable
- mem_addr  out  ADDR_WIDTH  buffer write address
- mem_data  out  SAMPLE_WIDTH  buffer write data
- trig_addr  out  ADDR_WIDTH  buffer address of trigger sample
- busy  out  1  capture in progress
- done  out  1  capture complete, buffer valid

Function
REQ-004 States SHALL be IDLE, ARM, PRE_FILL, WAIT_TRIG, POST, DONE.
REQ-005 start SHALL be accepted only in IDLE or DONE.
- On acceptance: latch cfg_rise/cfg_fall/cfg_pre/cfg_post, clear write pointer and counters, clear done, go to ARM.
REQ-006 ARM SHALL last exactly one cycle, then go to PRE_FILL.
REQ-007 trig_arm SHALL be 1 in ARM and PRE_FILL, and 0 in all other states.
REQ-008 In PRE_FILL, WAIT_TRIG and POST, one sample SHALL be written per cycle:
- mem_we=1, mem_data=sample_in, mem_addr=pointer; outputs registered, one-cycle latency.
- Pointer increments by 1 per write and wraps modulo 2^ADDR_WIDTH.
REQ-009 PRE_FILL SHALL write exactly the effective pre count of samples, then go to WAIT_TRIG.
- Effective pre count 0 goes directly from ARM to WAIT_TRIG.
- trig_run SHALL be ignored outside WAIT_TRIG.
REQ-010 Effective pre count SHALL be min(cfg_pre, 2^ADDR_WIDTH-1-cfg_post), computed at ADDR_WIDTH+1 bits, so pre + trigger + post samples never exceed buffer depth.
REQ-011 In WAIT_TRIG, when trig_run=1:
- trig_addr SHALL capture the address of the sample written that cycle.
- The state goes to POST with the post counter cleared.
- Waiting is unbounded, and the buffer overwrites circularly.
REQ-012 POST SHALL write exactly cfg_post further samples, then go to DONE.
- cfg_post=0 goes from WAIT_TRIG directly to DONE after the trigger sample.
REQ-013 In DONE:
- done=1 and mem_we=0; trig_addr is held.
- Remain until start (restart) or abort.
REQ-014 busy SHALL be 1 in ARM, PRE_FILL, WAIT_TRIG and POST.
REQ-015 abort SHALL move any state to IDLE on the next edge, with mem_we=0, trig_arm=0, done=0 and busy=0.
- abort has priority over start and trig_run in the same cycle.
- Buffer contents are undefined after abort.
REQ-016 trig_rise/trig_fall SHALL drive the latched values continuously, and change only on accepted start.
- All-zero selects cause a trigger on the first WAIT_TRIG cycle.

Reset
REQ-017 With reset_n=0 at a clock edge, the module SHALL enter IDLE and all outputs SHALL be 0.
- This includes trig_rise, trig_fall, trig_addr, mem_addr and done.
REQ-018 Reset mid-capture SHALL behave as abort, and all latched configuration SHALL be cleared.

Structure
REQ-019 Package capture_pkg SHALL hold the state enum typedef and the SAMPLE_WIDTH/ADDR_WIDTH defaults.
REQ-020 Pointer increment and wrap logic SHALL be one sub-module, capture_addr_gen (clear, enable, wrapping address out).

Verification
REQ-021 Bench SHALL cover these directed scenarios:
- ADDR_WIDTH=4, cfg_pre=3, cfg_post=2, trig_run pulse 5 cycles into WAIT_TRIG -> 3 PRE_FILL writes; trig_addr=8; 2 POST writes at addr 9,10; done=1; 11 total writes.
- cfg_pre=0, cfg_post=0, trig_run=1 on first WAIT_TRIG cycle -> one write at addr 0; trig_addr=0; done next cycle.
- ADDR_WIDTH=4, cfg_pre=15, cfg_post=4 -> effective pre=11; trig_run asserted during PRE_FILL ignored; trig_addr=11 when triggered on first WAIT_TRIG cycle.
- WAIT_TRIG held 20 cycles, ADDR_WIDTH=4 -> mem_addr wraps 15->0 with no gap.
- abort and trig_run in the same POST cycle -> IDLE; mem_we=0 next cycle; done stays 0.
- reset_n=0 mid-POST -> all outputs 0 next edge; start after release runs a full capture.
